// File: rtl/banked_ram_ctl.sv
// Single-clock banked scratch RAM with byte enables, 1- or 2-cycle registered reads,
// read-during-write forwarding and a self-timed clear sequencer.
module banked_ram_ctl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NBANKS   = 2,
    parameter int unsigned BANK_W   = 1,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BANK_W-1:0]     wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [BANK_W-1:0]     rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_start,
    output logic                  busy
);

    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned IDX_W     = BANK_W + ADDR_W;
    localparam int unsigned MEM_WORDS = 1 << IDX_W;
    localparam logic [BANK_W:0]    NBANKS_EXT = (BANK_W + 1)'(NBANKS);
    localparam logic [IDX_W-1:0]   LAST_IDX   = {BANK_W'(NBANKS - 1), {ADDR_W{1'b1}}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt, cnt_nx;
    logic               clr_we_c;

    // Flat storage indexed by {bank, addr}; slots of nonexistent banks are never written.
    logic [DATA_W-1:0]  mem [MEM_WORDS];

    logic [IDX_W-1:0]   wr_idx_c, rd_idx_c;
    logic               wr_acc_c, rd_acc_c, rd_bank_ok_c;
    logic [DATA_W-1:0]  rd_word_c;
    logic [DATA_W-1:0]  rd_data_s1;
    logic               rd_valid_s1;

    assign wr_idx_c     = {wr_bank, wr_addr};
    assign rd_idx_c     = {rd_bank, rd_addr};
    assign rd_bank_ok_c = ({1'b0, rd_bank} < NBANKS_EXT);
    assign wr_acc_c     = wr_en && !busy && ({1'b0, wr_bank} < NBANKS_EXT) && (wr_be != '0);
    assign rd_acc_c     = rd_en && !busy;

    // Read word selection, including same-edge write forwarding when enabled.
    always_comb begin
        rd_word_c = mem[rd_idx_c];
        if ((WR_FIRST != 0) && wr_acc_c && (wr_idx_c == rd_idx_c)) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (wr_be[i]) rd_word_c[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        if (!rd_bank_ok_c) rd_word_c = '0;
    end

    // Clear sequencer next-state logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we_c = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                clr_we_c = 1'b1;
                cnt_nx   = cnt + IDX_W'(1);
                if (cnt == LAST_IDX) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= (state_nx == CLEAR);
        end
    end

    // Storage is deliberately not reset; clear has priority over user writes.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[cnt] <= '0;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_idx_c][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_acc_c;
            if (rd_acc_c) rd_data_s1 <= rd_word_c;
        end
    end

    // Optional second output register; data already fetched drains even while busy.
    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_valid_s1;
                    if (rd_valid_s1) rd_data <= rd_data_s1;
                end
            end
        end else begin : g_lat1
            assign rd_data  = rd_data_s1;
            assign rd_valid = rd_valid_s1;
        end
    endgenerate

endmodule

// File: tb/tb_banked_ram_ctl.sv
// Directed bench for banked_ram_ctl: default instance, a read-old-data instance and a
// two-cycle-latency instance share one stimulus stream.
module tb_banked_ram_ctl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [0:0]  rd_bank;
    logic [1:0]  rd_addr;
    logic        clr_start;

    logic [15:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic        busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    banked_ram_ctl u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .clr_start(clr_start), .busy(busy_a)
    );

    banked_ram_ctl #(.WR_FIRST(0)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .clr_start(clr_start), .busy(busy_b)
    );

    banked_ram_ctl #(.RD_LAT(2)) u_dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .clr_start(clr_start), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input logic [0:0] b, input logic [1:0] a, input logic [15:0] d,
                         input logic [1:0] be);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input logic [0:0] b, input logic [1:0] a);
        rd_en = 1'b1; rd_bank = b; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0; clr_start = 1'b0;
        tick();
        tick();
        chk("rst_rd_data", rd_data_a, 16'h0000);
        chk("rst_rd_valid", 16'(rd_valid_a), 16'd0);
        chk("rst_busy", 16'(busy_a), 16'd0);
        chk("rst_rd_data_lat2", rd_data_c, 16'h0000);
        rst = 1'b0;
        tick();

        // Basic write/read, one-cycle valid pulse, two-cycle latency instance alongside
        do_wr(1'b0, 2'd0, 16'habcd, 2'b11);
        do_wr(1'b1, 2'd3, 16'hc0d1, 2'b11);
        do_rd(1'b0, 2'd0);
        chk("t1_rd0_valid", 16'(rd_valid_a), 16'd1);
        chk("t1_rd0_data", rd_data_a, 16'habcd);
        chk("t1_lat2_not_yet", 16'(rd_valid_c), 16'd0);
        do_rd(1'b1, 2'd3);
        chk("t1_rd1_valid", 16'(rd_valid_a), 16'd1);
        chk("t1_rd1_data", rd_data_a, 16'hc0d1);
        chk("t1_lat2_rd0_valid", 16'(rd_valid_c), 16'd1);
        chk("t1_lat2_rd0_data", rd_data_c, 16'habcd);
        tick();
        chk("t1_valid_drop", 16'(rd_valid_a), 16'd0);
        chk("t1_data_hold", rd_data_a, 16'hc0d1);
        chk("t1_lat2_rd1_data", rd_data_c, 16'hc0d1);
        tick();
        chk("t1_lat2_valid_drop", 16'(rd_valid_c), 16'd0);

        // Byte enables and the all-zero enable no-op
        do_wr(1'b0, 2'd1, 16'h79ca, 2'b11);
        do_wr(1'b0, 2'd1, 16'h1200, 2'b10);
        do_rd(1'b0, 2'd1);
        chk("t2_partial_be", rd_data_a, 16'h12ca);
        do_wr(1'b0, 2'd0, 16'hffff, 2'b00);
        do_rd(1'b0, 2'd0);
        chk("t2_be_zero_noop", rd_data_a, 16'habcd);

        // Read during write at the same location, then at different locations
        do_wr(1'b1, 2'd2, 16'hf4a2, 2'b11);
        wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 2'd2; wr_data = 16'h5555; wr_be = 2'b11;
        rd_en = 1'b1; rd_bank = 1'b1; rd_addr = 2'd2;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t3_rdw_wr_first", rd_data_a, 16'h5555);
        chk("t3_rdw_rd_first", rd_data_b, 16'hf4a2);
        do_rd(1'b1, 2'd2);
        chk("t3_after_wr_first", rd_data_a, 16'h5555);
        chk("t3_after_rd_first", rd_data_b, 16'h5555);
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 2'd2; wr_data = 16'h1111; wr_be = 2'b11;
        rd_en = 1'b1; rd_bank = 1'b0; rd_addr = 2'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t3_diff_loc_a", rd_data_a, 16'h12ca);
        chk("t3_diff_loc_b", rd_data_b, 16'h12ca);
        do_rd(1'b0, 2'd2);
        chk("t3_diff_loc_written", rd_data_a, 16'h1111);

        // Full clear with writes and reads attempted while busy
        for (int i = 0; i < 8; i++) do_wr(1'(i >> 2), 2'(i), 16'(32'h1000 + i), 2'b11);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("t4_busy_rise", 16'(busy_a), 16'd1);
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 2'd0; wr_data = 16'hbeef; wr_be = 2'b11;
        rd_en = 1'b1; rd_bank = 1'b0; rd_addr = 2'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t4_busy_held", 16'(busy_a), 16'd1);
            chk("t4_no_valid", 16'(rd_valid_a), 16'd0);
        end
        tick();
        chk("t4_busy_fall", 16'(busy_a), 16'd0);
        chk("t4_no_valid_last", 16'(rd_valid_a), 16'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_rd(1'(i >> 2), 2'(i));
            chk("t4_cleared_valid", 16'(rd_valid_a), 16'd1);
            chk("t4_cleared_data", rd_data_a, 16'h0000);
        end

        // Read issued with clr_start, in-flight lat2 read, reset in the middle of a clear
        for (int i = 0; i < 8; i++) do_wr(1'(i >> 2), 2'(i), 16'(32'h2000 + i), 2'b11);
        clr_start = 1'b1; rd_en = 1'b1; rd_bank = 1'b1; rd_addr = 2'd3;
        tick();
        clr_start = 1'b0; rd_en = 1'b0;
        chk("t5_start_read_data", rd_data_a, 16'h2007);
        chk("t5_start_read_valid", 16'(rd_valid_a), 16'd1);
        chk("t5_start_busy", 16'(busy_a), 16'd1);
        chk("t5_lat2_pending", 16'(rd_valid_c), 16'd0);
        tick();
        chk("t5_lat2_drain_valid", 16'(rd_valid_c), 16'd1);
        chk("t5_lat2_drain_data", rd_data_c, 16'h2007);
        chk("t5_a_valid_drop", 16'(rd_valid_a), 16'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 16'(busy_a), 16'd0);
        chk("t5_rst_valid", 16'(rd_valid_a), 16'd0);
        chk("t5_rst_data", rd_data_a, 16'h0000);
        chk("t5_rst_data_lat2", rd_data_c, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_idle_after_rst", 16'(busy_a), 16'd0);
        for (int i = 0; i < 8; i++) begin
            do_rd(1'(i >> 2), 2'(i));
            chk("t5_partial_clear", rd_data_a, (i < 3) ? 16'h0000 : 16'(32'h2000 + i));
        end
        tick();
        tick();

        // Back-to-back reads through the two-cycle pipeline
        rd_en = 1'b1; rd_bank = 1'b1; rd_addr = 2'd3;
        tick();
        chk("t6_lat2_first_edge", 16'(rd_valid_c), 16'd0);
        chk("t6_lat1_first", rd_data_a, 16'h2007);
        rd_bank = 1'b1; rd_addr = 2'd2;
        tick();
        chk("t6_v0", 16'(rd_valid_c), 16'd1);
        chk("t6_d0", rd_data_c, 16'h2007);
        rd_bank = 1'b0; rd_addr = 2'd3;
        tick();
        chk("t6_v1", 16'(rd_valid_c), 16'd1);
        chk("t6_d1", rd_data_c, 16'h2006);
        rd_bank = 1'b1; rd_addr = 2'd0;
        tick();
        chk("t6_v2", 16'(rd_valid_c), 16'd1);
        chk("t6_d2", rd_data_c, 16'h2003);
        rd_en = 1'b0;
        tick();
        chk("t6_v3", 16'(rd_valid_c), 16'd1);
        chk("t6_d3", rd_data_c, 16'h2004);
        tick();
        chk("t6_valid_end", 16'(rd_valid_c), 16'd0);
        chk("t6_data_hold", rd_data_c, 16'h2004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
